// File: rtl/dmem_arb_pkg.sv
// ============================================================================
// Module  : dmem_arb_pkg
// Brief   : Shared types, requester ids and address check for dmem_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam int unsigned DEPTH_WORDS_DEFAULT = 64;

    // Word aligned and word index inside the memory; all upper bits take part.
    function automatic logic addr_ok(input logic [63:0] addr, input int unsigned depth);
        return (addr[1:0] == 2'b00) && ((addr >> 2) < 64'(depth));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Combinational two-way round-robin picker.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt_id
);

    always_comb begin
        gnt_valid = req[0] | req[1];
        gnt_id    = M0;
        if (req == 2'b10) begin
            gnt_id = M1;
        end else if (req == 2'b11) begin
            gnt_id = ~last_grant;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Round-robin arbiter/sequencer for a single-port data memory.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_ack,
    output logic          m0_err,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_ack,
    output logic          m1_err,
    output logic [DW-1:0] m1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd,
    output logic          busy
);

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last_grant;
    logic          r_id;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic [1:0]    w_req;
    logic          w_gnt_valid;
    logic          w_gnt_id;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_legal;

    assign w_req = {m1_req, m0_req};

    rr_arb2 u_rr_arb2 (
        .req        (w_req),
        .last_grant (r_last_grant),
        .gnt_valid  (w_gnt_valid),
        .gnt_id     (w_gnt_id)
    );

    assign w_we    = (w_gnt_id == M1) ? m1_we    : m0_we;
    assign w_addr  = (w_gnt_id == M1) ? m1_addr  : m0_addr;
    assign w_wdata = (w_gnt_id == M1) ? m1_wdata : m0_wdata;
    assign w_legal = addr_ok(64'(w_addr), DEPTH_WORDS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rejected requests skip ACCESS so the memory is never driven for them.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_valid) w_state_nxt = w_legal ? ACCESS : RESP;
            ACCESS:  w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= M1;
            r_id         <= M0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else if (r_state == IDLE && w_gnt_valid) begin
            r_id    <= w_gnt_id;
            r_we    <= w_we;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_err   <= ~w_legal;
            if (!w_legal) r_rdata <= '0;
            if (&w_req) r_last_grant <= w_gnt_id;
        end else if (r_state == ACCESS) begin
            r_rdata <= r_we ? '0 : mem_rd;
        end
    end

    assign mem_we   = (r_state == ACCESS) && r_we;
    assign mem_a    = r_addr;
    assign mem_wd   = r_wdata;
    assign busy     = (r_state != IDLE);

    assign m0_ack   = (r_state == RESP) && (r_id == M0);
    assign m1_ack   = (r_state == RESP) && (r_id == M1);
    assign m0_err   = m0_ack & r_err;
    assign m1_err   = m1_ack & r_err;
    assign m0_rdata = m0_ack ? r_rdata : '0;
    assign m1_rdata = m1_ack ? r_rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module  : tb_dmem_arbiter
// Brief   : Self-checking bench for dmem_arbiter with a transaction-level model.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_dmem_arbiter;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_req, m0_we, m0_ack, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_ack, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          mem_we, busy;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;

    dmem_arbiter #(.AW(AW), .DW(DW), .DEPTH_WORDS(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_err   (m0_err),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_err   (m1_err),
        .m1_rdata (m1_rdata),
        .mem_we   (mem_we),
        .mem_a    (mem_a),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Memory under the arbiter: asynchronous read, write on the rising edge.
    logic [DW-1:0] mem [DEPTH];
    assign mem_rd = mem[mem_a[7:2]];
    always @(posedge clk) if (mem_we) mem[mem_a[7:2]] = mem_wd;

    int   wr_cnt = 0;
    int   proto_cnt = 0;
    logic p0 = 1'b0, p1 = 1'b0;
    always @(posedge clk) begin
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if ((m0_ack && m1_ack) || (m0_ack && p0) || (m1_ack && p1)) proto_cnt <= proto_cnt + 1;
        p0 <= m0_ack;
        p1 <= m1_ack;
    end

    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; bit drop; } txn_t;
    typedef struct { int at_edge; logic err; logic [31:0] rdata; } exp_t;

    txn_t          q0[$], q1[$];
    logic [31:0]   ref_mem [DEPTH];
    logic          model_lg;
    int            n_tests = 0;
    int            n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    function automatic txn_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
        txn_t t;
        t.we = we; t.addr = a; t.wdata = d; t.drop = 1'b0;
        return t;
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned k = $urandom_range(0, 9);
        logic [31:0] a = 32'($urandom_range(0, 15)) << 2;
        if (k == 7) a = 32'd63 << 2;
        else if (k == 8) a = a | 32'($urandom_range(1, 3));
        else if (k == 9) a = a | (32'd1 << $urandom_range(8, 31));
        return a;
    endfunction

    task automatic drive0();
        if (q0.size() > 0) begin
            m0_req = 1'b1; m0_we = q0[0].we; m0_addr = q0[0].addr; m0_wdata = q0[0].wdata;
        end else begin
            m0_req = 1'b0;
        end
    endtask

    task automatic drive1();
        if (q1.size() > 0) begin
            m1_req = 1'b1; m1_we = q1[0].we; m1_addr = q1[0].addr; m1_wdata = q1[0].wdata;
        end else begin
            m1_req = 1'b0;
        end
    endtask

    // Every queued request is pending at each arbitration point, so the model
    // just walks the queues: tie -> the one not granted last, legal = 3 cycles,
    // rejected = 2 cycles, ack observed 1 (legal) or 0 (rejected) edges after sampling.
    task automatic run_batch(input string name);
        txn_t m0q[$], m1q[$];
        exp_t e0[$], e1[$];
        int   t, n_wr, cyc, wr_base, pr_base;
        m0q = q0; m1q = q1; t = 1; n_wr = 0;
        while (m0q.size() > 0 || m1q.size() > 0) begin
            txn_t x;
            exp_t e;
            bit   w;
            if (m0q.size() > 0 && m1q.size() > 0) begin
                w = !model_lg;
                model_lg = w;
            end else begin
                w = (m0q.size() == 0);
            end
            x = w ? m1q.pop_front() : m0q.pop_front();
            e.err   = !legal(x.addr);
            e.rdata = '0;
            if (!e.err) begin
                if (x.we) begin
                    ref_mem[x.addr / 4] = x.wdata;
                    n_wr++;
                end else begin
                    e.rdata = ref_mem[x.addr / 4];
                end
            end
            e.at_edge = t + (e.err ? 0 : 1);
            t = e.at_edge + 2;
            if (w) e1.push_back(e); else e0.push_back(e);
        end

        wr_base = wr_cnt;
        pr_base = proto_cnt;
        drive0();
        drive1();
        cyc = 0;
        while ((e0.size() > 0 || e1.size() > 0) && cyc < t + 8) begin
            @(posedge clk); #1;
            cyc++;
            if (cyc == 1 && q0.size() > 0 && q0[0].drop) m0_req = 1'b0;
            if (m0_ack) begin
                if (e0.size() == 0) begin
                    check({name, "/m0_extra_ack"}, 1, 0);
                end else begin
                    exp_t e;
                    e = e0.pop_front();
                    check({name, "/m0_ack_cycle"}, 64'(cyc), 64'(e.at_edge));
                    check({name, "/m0_err"}, m0_err, e.err);
                    check({name, "/m0_rdata"}, m0_rdata, e.rdata);
                    check({name, "/m1_quiet"}, {m1_ack, m1_err, m1_rdata}, 0);
                    void'(q0.pop_front());
                    drive0();
                end
            end
            if (m1_ack) begin
                if (e1.size() == 0) begin
                    check({name, "/m1_extra_ack"}, 1, 0);
                end else begin
                    exp_t e;
                    e = e1.pop_front();
                    check({name, "/m1_ack_cycle"}, 64'(cyc), 64'(e.at_edge));
                    check({name, "/m1_err"}, m1_err, e.err);
                    check({name, "/m1_rdata"}, m1_rdata, e.rdata);
                    check({name, "/m0_quiet"}, {m0_ack, m0_err, m0_rdata}, 0);
                    void'(q1.pop_front());
                    drive1();
                end
            end
        end
        if (e0.size() + e1.size() > 0) check({name, "/timeout_missing_acks"}, 64'(e0.size() + e1.size()), 0);
        q0.delete();
        q1.delete();
        m0_req = 1'b0;
        m1_req = 1'b0;
        @(posedge clk); #1;
        check({name, "/writes"}, 64'(wr_cnt - wr_base), 64'(n_wr));
        check({name, "/ack_protocol"}, 64'(proto_cnt - pr_base), 0);
        check({name, "/idle_busy"}, busy, 0);
    endtask

    initial begin
        logic [31:0] old3;
        txn_t        d;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom;
            ref_mem[i] = mem[i];
        end
        model_lg = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst/flags", {m0_ack, m0_err, m1_ack, m1_err, mem_we, busy}, 0);
        check("rst/rdata", {m0_rdata, m1_rdata}, 0);
        check("rst/mem_bus", {mem_a, mem_wd}, 0);
        rst_n = 1'b1;

        mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        q0.push_back(mk(1'b0, 32'h14, '0));
        run_batch("single_read");

        q1.push_back(mk(1'b1, 32'h08, 32'hCAFEF00D));
        q1.push_back(mk(1'b0, 32'h08, '0));
        run_batch("write_read");

        for (int i = 0; i < 3; i++) begin
            q0.push_back(mk(1'b0, 32'(i * 4), '0));
            q1.push_back(mk(1'b0, 32'(i * 4 + 32), '0));
        end
        run_batch("tie_rr");

        q0.push_back(mk(1'b0, 32'h0000_0002, '0));
        q1.push_back(mk(1'b1, 32'h0000_0100, 32'h1234));
        run_batch("illegal");

        d = mk(1'b1, 32'h10, 32'h55);
        d.drop = 1'b1;
        q0.push_back(d);
        run_batch("dropped_req");
        check("dropped_req/word4", mem[4], 32'h55);

        old3 = mem[3];
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0C; m0_wdata = 32'h1;
        @(posedge clk); #1;
        check("rst_mid/in_access", {busy, mem_we}, 2'b11);
        rst_n = 1'b0;
        #1;
        check("rst_mid/async", {busy, m0_ack, m1_ack, mem_we}, 0);
        m0_req = 1'b0;
        @(posedge clk); #1;
        check("rst_mid/word3", mem[3], old3);
        model_lg = 1'b1;
        rst_n = 1'b1;
        q0.push_back(mk(1'b0, 32'h0C, '0));
        q1.push_back(mk(1'b0, 32'h0C, '0));
        run_batch("rst_mid_tie");

        for (int b = 0; b < 12; b++) begin
            int n0 = $urandom_range(0, 3);
            int n1 = $urandom_range(0, 3);
            for (int i = 0; i < n0; i++) q0.push_back(mk(1'($urandom), rand_addr(), $urandom));
            for (int i = 0; i < n1; i++) q1.push_back(mk(1'($urandom), rand_addr(), $urandom));
            run_batch($sformatf("rand%0d", b));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
